// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: sweep handshake, configuration inputs,
// spike vector and membrane readback. The master modport is the controller side
// and the slave modport is the neuron array side.
interface lif_neuron_array_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RW = 3
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic              ena;
  logic              step;
  logic [N*W-1:0]    current_in;
  logic [W-1:0]      threshold;
  logic [2:0]        leak_shift;
  logic [RW-1:0]     refrac_len;
  logic              busy;
  logic              done;
  logic [N-1:0]      spikes;
  logic [IW-1:0]     rd_sel;
  logic [W-1:0]      rd_mem;

  modport master (
    output ena, step, current_in, threshold, leak_shift, refrac_len, rd_sel,
    input  busy, done, spikes, rd_mem
  );

  modport slave (
    input  ena, step, current_in, threshold, leak_shift, refrac_len, rd_sel,
    output busy, done, spikes, rd_mem
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of N leaky integrate-and-fire neurons sharing one datapath.
// A step request snapshots the configuration, then one neuron is updated per
// cycle; the spike vector is published one cycle after the last neuron.
module lif_neuron_array #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  lif_neuron_array_if.slave     bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            snap_en, upd_en, fin;

  // Snapshot of the sweep configuration, frozen for the whole sweep
  logic [W-1:0]    cur_q [N];
  logic [W-1:0]    thr_q;
  logic [2:0]      ls_q;
  logic [RW-1:0]   rl_q;

  // Neuron state register file
  logic [W-1:0]    u_q  [N];
  logic [RW-1:0]   rf_q [N];
  logic [N-1:0]    shadow_q;
  logic [N-1:0]    spikes_q;
  logic            done_q;

  // Shared datapath signals for the neuron selected by idx_q
  logic [W-1:0]    u_cur, i_cur, leak, decayed, u_new;
  logic [W:0]      sum;
  logic [W-1:0]    un;
  logic [RW-1:0]   rf_cur, rf_new;
  logic            spk_new;

  // Clamp a W+1-bit unsigned sum to the W-bit range
  function automatic logic [W-1:0] sat_u(input logic [W:0] x);
    if (x[W]) sat_u = {W{1'b1}};
    else      sat_u = x[W-1:0];
  endfunction

  // Next-state and control strobes for the sweep sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_en = 1'b0;
    upd_en  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.step) begin
          snap_en = 1'b1;
          idx_d   = '0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        upd_en = 1'b1;
        if (idx_q == IW'(N-1)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        fin     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Leak, integrate, saturate and threshold for the current neuron
  always_comb begin
    u_cur   = u_q[idx_q];
    rf_cur  = rf_q[idx_q];
    i_cur   = cur_q[idx_q];
    leak    = u_cur >> ls_q;
    decayed = u_cur - leak;
    sum     = {1'b0, decayed} + {1'b0, i_cur};
    un      = sat_u(sum);
    u_new   = '0;
    rf_new  = '0;
    spk_new = 1'b0;
    if (rf_cur != '0) begin
      rf_new = rf_cur - RW'(1);
    end else if (un >= thr_q) begin
      spk_new = 1'b1;
      rf_new  = rl_q;
    end else begin
      u_new = un;
    end
  end

  // Control, membrane and refractory state; everything holds while ena is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      done_q   <= 1'b0;
      spikes_q <= '0;
      shadow_q <= '0;
      for (int k = 0; k < N; k++) begin
        u_q[k]  <= '0;
        rf_q[k] <= '0;
      end
    end else if (bus.ena) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= fin;
      if (fin) spikes_q <= shadow_q;
      if (upd_en) begin
        u_q[idx_q]      <= u_new;
        rf_q[idx_q]     <= rf_new;
        shadow_q[idx_q] <= spk_new;
      end
    end
  end

  // Configuration snapshot taken when a sweep is accepted
  always_ff @(posedge clk) begin
    if (bus.ena && snap_en && !rst) begin
      for (int k = 0; k < N; k++) cur_q[k] <= bus.current_in[k*W +: W];
      thr_q <= bus.threshold;
      ls_q  <= bus.leak_shift;
      rl_q  <= bus.refrac_len;
    end
  end

  assign bus.busy   = (state_q == S_UPDATE);
  assign bus.done   = done_q;
  assign bus.spikes = spikes_q;
  assign bus.rd_mem = u_q[bus.rd_sel];

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array (N=4, W=8, RW=3) with hand-computed
// expected membranes, spike vectors and handshake timing.
module tb_lif_neuron_array;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  lif_neuron_array_if #(.N(4), .W(8), .RW(3)) bus ();

  lif_neuron_array #(.N(4), .W(8), .RW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] thr, input logic [2:0] ls, input logic [2:0] rl,
                         input logic [7:0] i0, input logic [7:0] i1,
                         input logic [7:0] i2, input logic [7:0] i3);
    bus.threshold  = thr;
    bus.leak_shift = ls;
    bus.refrac_len = rl;
    bus.current_in = {i3, i2, i1, i0};
  endtask

  task automatic check_u(input string tag, input logic [1:0] k, input logic [7:0] exp);
    bus.rd_sel = k;
    #1;
    check(tag, bus.rd_mem, exp);
  endtask

  // One full sweep; done must show 5 edges after the step edge
  task automatic do_sweep(input string tag);
    int lat;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 5);
  endtask

  int exp_u [7] = '{40, 70, 93, 0, 0, 0, 40};
  int exp_s [7] = '{0, 0, 0, 1, 0, 0, 0};

  initial begin
    int seen;
    int lat;
    bus.ena    = 1'b1;
    bus.step   = 1'b0;
    bus.rd_sel = '0;
    set_cfg(8'd100, 3'd2, 3'd2, 8'd40, 8'd0, 8'd0, 8'd0);
    tick();
    do_reset();

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_spikes", bus.spikes, 0);
    check_u("rst_u0", 2'd0, 8'd0);

    // Integration, fire and refractory over seven sweeps
    for (int s = 0; s < 7; s++) begin
      do_sweep($sformatf("sc1_sw%0d", s + 1));
      check($sformatf("sc1_spk%0d", s + 1), bus.spikes, exp_s[s]);
      check_u($sformatf("sc1_u0_%0d", s + 1), 2'd0, exp_u[s][7:0]);
      check_u($sformatf("sc1_u1_%0d", s + 1), 2'd1, 8'd0);
    end

    // Latency and handshake with step held high during busy
    do_reset();
    set_cfg(8'd100, 3'd2, 3'd2, 8'd40, 8'd0, 8'd0, 8'd0);
    bus.step = 1'b1;
    tick();
    for (int o = 0; o < 10; o++) begin
      if (o > 0) tick();
      check($sformatf("sc3_busy_o%0d", o), bus.busy, (o <= 3) ? 1 : 0);
      check($sformatf("sc3_done_o%0d", o), bus.done, (o == 5) ? 1 : 0);
      if (o == 4) bus.step = 1'b0;
    end
    check_u("sc3_u0", 2'd0, 8'd40);

    // Saturation
    do_reset();
    set_cfg(8'd255, 3'd7, 3'd2, 8'd0, 8'd200, 8'd0, 8'd0);
    do_sweep("sc4_sw1");
    check("sc4_spk1", bus.spikes, 4'b0000);
    check_u("sc4_u1_1", 2'd1, 8'd200);
    do_sweep("sc4_sw2");
    check("sc4_spk2", bus.spikes, 4'b0010);
    check_u("sc4_u1_2", 2'd1, 8'd0);

    // Reset in the second busy cycle discards the sweep
    do_reset();
    set_cfg(8'd100, 3'd2, 3'd2, 8'd40, 8'd0, 8'd0, 8'd0);
    do_sweep("sc5_pre");
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sc5_busy", bus.busy, 0);
    check("sc5_done", bus.done, 0);
    check("sc5_spikes", bus.spikes, 0);
    for (int k = 0; k < 4; k++) check_u($sformatf("sc5_u%0d", k), k[1:0], 8'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.done || bus.busy) seen = 1;
    end
    check("sc5_quiet", seen, 0);

    // ena freeze for three cycles mid-sweep
    do_reset();
    set_cfg(8'd100, 3'd2, 3'd2, 8'd40, 8'd0, 8'd0, 8'd0);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    bus.ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("sc6_frz_busy%0d", c), bus.busy, 1);
      check_u($sformatf("sc6_frz_u1_%0d", c), 2'd1, 8'd0);
    end
    check_u("sc6_frz_u0", 2'd0, 8'd40);
    bus.ena = 1'b1;
    lat = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    check("sc6_resume_lat", lat, 4);
    check("sc6_spk1", bus.spikes, 0);
    check_u("sc6_u0_1", 2'd0, 8'd40);
    do_sweep("sc6_sw2");
    check_u("sc6_u0_2", 2'd0, 8'd70);
    do_sweep("sc6_sw3");
    check_u("sc6_u0_3", 2'd0, 8'd93);
    do_sweep("sc6_sw4");
    check("sc6_spk4", bus.spikes, 4'b0001);
    check_u("sc6_u0_4", 2'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
